dsram_responder: RTL

- Data-SRAM responder that sits at the far end of the execute stage's data memory request port (data_sram_en/wen/addr/wdata).
- Accepts one load or store at a time, models a configurable number of wait states, and performs byte-masked writes into an internal word array.
- Returns read data with a one-cycle completion pulse, and requests a pipeline stall while a transaction is outstanding.
- Used as the data memory for core bring-up and as the reference slave for verifying the memory stage.

---
 rtl/dsram_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dsram_responder.sv
// Data-SRAM responder: one load/store at a time, WAIT_CYCLES wait states,
// byte-masked writes, registered read data with a one-cycle completion pulse.
module dsram_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_ok_o,
   output logic        stallreq_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [3:0]            wen_q;
   logic [31:0]           wdata_q;
   logic [31:0]           mem [DEPTH];

   logic                  accept;
   logic                  access;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [3:0]            acc_wen;
   logic [31:0]           acc_wdata;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

   assign accept = (state_q == S_IDLE) && data_sram_en;
   // Array access happens on the edge entering RESP; reset suppresses it.
   assign access = rst_n && (state_d == S_RESP);

   // With zero wait states the access edge is the accept edge, so use live inputs.
   always_comb begin
      acc_idx   = idx_q;
      acc_wen   = wen_q;
      acc_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         acc_idx   = data_sram_addr[DEPTH_LOG2+1:2];
         acc_wen   = data_sram_wen;
         acc_wdata = data_sram_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (data_sram_en) begin
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= 4'd0;
         idx_q           <= '0;
         wen_q           <= 4'd0;
         wdata_q         <= 32'd0;
         data_sram_rdata <= 32'd0;
         data_ok_o       <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_ok_o <= (state_d == S_RESP);
         if (accept) begin
            idx_q   <= data_sram_addr[DEPTH_LOG2+1:2];
            wen_q   <= data_sram_wen;
            wdata_q <= data_sram_wdata;
         end
         if (state_d == S_RESP) data_sram_rdata <= mem[acc_idx];
      end
   end

   // Read-before-write: rdata captures the old word on the same edge.
   always_ff @(posedge clk) begin
      if (access) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wen[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign stallreq_o = rst_n && (accept || (state_q == S_WAIT));

endmodule
